// File: rtl/ui_resp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ui_resp_gen
//  Function : UART UI response generator; writes OK/ERR/hex-data responses
//             and parser echo characters into the transmit character FIFO.
//  Revision : 1.0
// ============================================================================
module ui_resp_gen #(
    parameter int CWIDTH  = 24,
    parameter int PWIDTH  = 36,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_char_val,
    input  logic [7:0]        send_char,
    input  logic              send_resp_val,
    input  logic [1:0]        send_resp_type,
    output logic              send_resp_done,
    input  logic              chrg_rd_valid,
    input  logic [CWIDTH-1:0] chrg_rd_data,
    input  logic              phi_rd_valid,
    input  logic [PWIDTH-1:0] phi_rd_data,
    input  logic              char_fifo_full,
    output logic              char_fifo_wr,
    output logic [7:0]        char_fifo_din
);

    localparam int              CNTW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    localparam logic [1:0] T_OK  = 2'b00;
    localparam logic [1:0] T_ERR = 2'b01;
    localparam logic [1:0] T_D0  = 2'b10;
    localparam logic [1:0] T_D1  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [1:0]      type_q;
    logic [35:0]     hold_q;
    logic [3:0]      idx_q;
    logic [CNTW-1:0] cnt_q;
    logic            done_q;
    logic            wr_q;
    logic [7:0]      din_q;

    logic            start_send_d;
    logic [1:0]      start_type_d;
    logic [35:0]     start_data_d;
    logic [1:0]      cur_type_d;
    logic [35:0]     cur_data_d;
    logic [3:0]      cur_idx_d;
    logic            resp_active_d;
    logic            resp_wr_d;
    logic            resp_last_d;
    logic [7:0]      resp_char_d;
    logic [35:0]     chrg_ext;
    logic [35:0]     phi_ext;

    assign chrg_ext = 36'(chrg_rd_data);
    assign phi_ext  = 36'(phi_rd_data);

    function automatic logic [3:0] last_idx(input logic [1:0] t);
        case (t)
            T_OK:    return 4'd3;
            T_ERR:   return 4'd4;
            T_D0:    return 4'd7;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] resp_char(input logic [1:0] t, input logic [35:0] d,
                                             input logic [3:0] i);
        logic [3:0] ndig;
        logic [5:0] amt;
        logic [3:0] nib;
        logic [7:0] c;
        ndig = (t == T_D0) ? 4'd6 : 4'd9;
        amt  = {ndig - 4'd1 - i, 2'b00};
        nib  = 4'(d >> amt);
        c    = 8'h0A;
        case (t)
            T_OK: begin
                case (i)
                    4'd0:    c = 8'h4F;
                    4'd1:    c = 8'h4B;
                    4'd2:    c = 8'h0D;
                    default: c = 8'h0A;
                endcase
            end
            T_ERR: begin
                case (i)
                    4'd0:       c = 8'h45;
                    4'd1, 4'd2: c = 8'h52;
                    4'd3:       c = 8'h0D;
                    default:    c = 8'h0A;
                endcase
            end
            default: begin
                if (i < ndig)
                    c = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
                else if (i == ndig)
                    c = 8'h0D;
                else
                    c = 8'h0A;
            end
        endcase
        return c;
    endfunction

    // The cycle that enters SEND already emits character 0, using the request
    // type and freshly captured data directly, so the first write is not delayed.
    always_comb begin
        start_send_d = 1'b0;
        start_type_d = type_q;
        start_data_d = hold_q;
        case (state_q)
            S_IDLE: begin
                if (send_resp_val) begin
                    start_type_d = send_resp_type;
                    case (send_resp_type)
                        T_OK, T_ERR: start_send_d = 1'b1;
                        T_D0: begin
                            if (chrg_rd_valid) begin
                                start_send_d = 1'b1;
                                start_data_d = chrg_ext;
                            end
                        end
                        default: begin
                            if (phi_rd_valid) begin
                                start_send_d = 1'b1;
                                start_data_d = phi_ext;
                            end
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if ((type_q == T_D0) ? chrg_rd_valid : phi_rd_valid) begin
                    start_send_d = 1'b1;
                    start_data_d = (type_q == T_D0) ? chrg_ext : phi_ext;
                end else if (cnt_q == CNT_LAST) begin
                    start_send_d = 1'b1;
                    start_type_d = T_ERR;
                end
            end
            default: ;
        endcase
        cur_type_d    = start_send_d ? start_type_d : type_q;
        cur_data_d    = start_send_d ? start_data_d : hold_q;
        cur_idx_d     = start_send_d ? 4'd0 : idx_q;
        resp_active_d = start_send_d || (state_q == S_SEND);
        resp_wr_d     = resp_active_d && !char_fifo_full && !send_char_val;
        resp_last_d   = (cur_idx_d == last_idx(cur_type_d));
        resp_char_d   = resp_char(cur_type_d, cur_data_d, cur_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            type_q  <= T_OK;
            hold_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            din_q   <= 8'h00;
        end else begin
            done_q <= (state_q == S_DONE);

            // Echo characters win the FIFO port; a stalled response char retries.
            if (send_char_val && !char_fifo_full) begin
                wr_q  <= 1'b1;
                din_q <= send_char;
            end else if (resp_wr_d) begin
                wr_q  <= 1'b1;
                din_q <= resp_char_d;
            end else begin
                wr_q  <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (send_resp_val) begin
                        type_q  <= send_resp_type;
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT:  cnt_q   <= cnt_q + CNTW'(1);
                S_DONE:  state_q <= S_IDLE;
                default: ;
            endcase

            if (start_send_d) begin
                type_q  <= start_type_d;
                hold_q  <= start_data_d;
                state_q <= S_SEND;
            end

            if (resp_active_d) begin
                if (resp_wr_d) begin
                    if (resp_last_d) begin
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= cur_idx_d + 4'd1;
                    end
                end else begin
                    idx_q <= cur_idx_d;
                end
            end
        end
    end

    assign send_resp_done = done_q;
    assign char_fifo_wr   = wr_q;
    assign char_fifo_din  = din_q;

endmodule
`default_nettype wire

// File: tb/tb_ui_resp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ui_resp_gen
//  Function : Self-checking bench for ui_resp_gen (vector table, corner-case
//             sequences and randomized traffic against a string-level model).
//  Revision : 1.0
// ============================================================================
module tb_ui_resp_gen;

    localparam int CW = 24;
    localparam int PW = 36;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          send_char_val;
    logic [7:0]    send_char;
    logic          send_resp_val;
    logic [1:0]    send_resp_type;
    logic          send_resp_done;
    logic          chrg_rd_valid;
    logic [CW-1:0] chrg_rd_data;
    logic          phi_rd_valid;
    logic [PW-1:0] phi_rd_data;
    logic          char_fifo_full;
    logic          char_fifo_wr;
    logic [7:0]    char_fifo_din;

    ui_resp_gen #(.CWIDTH(CW), .PWIDTH(PW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .send_char_val  (send_char_val),
        .send_char      (send_char),
        .send_resp_val  (send_resp_val),
        .send_resp_type (send_resp_type),
        .send_resp_done (send_resp_done),
        .chrg_rd_valid  (chrg_rd_valid),
        .chrg_rd_data   (chrg_rd_data),
        .phi_rd_valid   (phi_rd_valid),
        .phi_rd_data    (phi_rd_data),
        .char_fifo_full (char_fifo_full),
        .char_fifo_wr   (char_fifo_wr),
        .char_fifo_din  (char_fifo_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] b;
    } wr_t;

    typedef struct {
        logic [1:0]    typ;
        logic [35:0]   data;
        int            vd;
        int            len;
        logic [87:0]   exp;
    } vec_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   nresp = 0;
    logic prev_full = 1'b0;
    wr_t  wq[$];
    int   dq[$];
    int   exp_cyc[$];
    logic [7:0] exp_resp[$];
    logic [7:0] exp_echo[$];
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe every FIFO write and done pulse mid-cycle
    always @(negedge clk) begin
        if (char_fifo_wr === 1'b1) begin
            wq.push_back('{cyc, char_fifo_din});
            if (!(char_fifo_din >= 8'h61 && char_fifo_din <= 8'h7A)) nresp++;
            checks++;
            if (prev_full) begin
                errors++;
                $display("FAIL wr_while_full cyc=%0d: got write=1 expected write=0", cyc);
            end
        end
        if (send_resp_done === 1'b1) dq.push_back(cyc);
        prev_full = char_fifo_full;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        send_resp_val = 1'b0;
        send_char_val = 1'b0;
        chrg_rd_valid = 1'b0;
        phi_rd_valid  = 1'b0;
    endtask

    // Compare captured writes against expected bytes and exp_cyc; dc<0 means no done
    task automatic check_seq(input string nm, input logic [87:0] exp, input int len, input int dc);
        chk({nm, "_count"}, wq.size(), len);
        for (int i = 0; i < len && i < wq.size(); i++) begin
            chk($sformatf("%s_byte%0d", nm, i), wq[i].b, exp[8*(len-1-i) +: 8]);
            chk($sformatf("%s_cyc%0d", nm, i), wq[i].c, exp_cyc[i]);
        end
        if (dc < 0) begin
            chk({nm, "_nodone"}, dq.size(), 0);
        end else begin
            chk({nm, "_done_count"}, dq.size(), 1);
            if (dq.size() > 0) chk({nm, "_done_cyc"}, dq[0], dc);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int r, m;
        wq.delete(); dq.delete(); exp_cyc.delete();
        tick();
        r = cyc;
        m = r;
        send_resp_val  = 1'b1;
        send_resp_type = v.typ;
        if (v.typ[1]) begin
            if (v.vd > 0) repeat (v.vd) tick();
            if (v.typ == 2'b10) begin
                chrg_rd_valid = 1'b1;
                chrg_rd_data  = v.data[23:0];
            end else begin
                phi_rd_valid = 1'b1;
                phi_rd_data  = v.data;
            end
            m = cyc;
        end
        tick();
        chrg_rd_data = ~v.data[23:0];
        phi_rd_data  = ~v.data;
        repeat (v.len + 3) tick();
        for (int i = 0; i < v.len; i++) exp_cyc.push_back(m + 1 + i);
        check_seq($sformatf("vec%0d", k), v.exp, v.len, m + v.len + 1);
    endtask

    // Expected response text derived from the encoding rules
    task automatic model_push(input logic [1:0] t, input logic [35:0] d);
        int nd;
        logic [3:0] n;
        case (t)
            2'b00: begin exp_resp.push_back(8'h4F); exp_resp.push_back(8'h4B); end
            2'b01: begin
                exp_resp.push_back(8'h45); exp_resp.push_back(8'h52); exp_resp.push_back(8'h52);
            end
            default: begin
                nd = (t == 2'b10) ? 6 : 9;
                for (int i = nd - 1; i >= 0; i--) begin
                    n = 4'(d >> (4 * i));
                    exp_resp.push_back(n < 10 ? 8'h30 + 8'(n) : 8'h41 + 8'(n - 10));
                end
            end
        endcase
        exp_resp.push_back(8'h0D);
        exp_resp.push_back(8'h0A);
    endtask

    initial begin
        int r, k, dbase, rbase, len, vd;
        logic [1:0]  typ;
        logic [35:0] d;
        bit          tmo, sent;
        logic [7:0]  resp_got[$];
        logic [7:0]  echo_got[$];

        vecs[0] = '{2'b00, 36'h0,         0, 4,  88'("OK\015\012")};
        vecs[1] = '{2'b01, 36'h0,         0, 5,  88'("ERR\015\012")};
        vecs[2] = '{2'b10, 36'h0_000ABCDE, 2, 8,  88'("0ABCDE\015\012")};
        vecs[3] = '{2'b11, 36'hF_00000001, 0, 11, 88'("F00000001\015\012")};
        vecs[4] = '{2'b10, 36'h0_00000000, 0, 8,  88'("000000\015\012")};
        vecs[5] = '{2'b11, 36'h1_23456789, 5, 11, 88'("123456789\015\012")};
        vecs[6] = '{2'b10, 36'h0_00FFFFFF, 1, 8,  88'("FFFFFF\015\012")};

        rst = 1'b1;
        send_char_val = 1'b0; send_char = 8'h00;
        send_resp_val = 1'b0; send_resp_type = 2'b00;
        chrg_rd_valid = 1'b0; chrg_rd_data = '1;
        phi_rd_valid  = 1'b0; phi_rd_data  = '1;
        char_fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr", char_fifo_wr, 0);
        chk("reset_din", char_fifo_din, 8'h00);
        chk("reset_done", send_resp_done, 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // FIFO full for three cycles in the middle of ERR
        wq.delete(); dq.delete(); exp_cyc.delete();
        tick(); r = cyc;
        send_resp_val = 1'b1; send_resp_type = 2'b01;
        tick(); tick();
        char_fifo_full = 1'b1;
        tick(); tick(); tick();
        char_fifo_full = 1'b0;
        repeat (8) tick();
        exp_cyc = {r + 1, r + 2, r + 6, r + 7, r + 8};
        check_seq("full_err", 88'("ERR\015\012"), 5, r + 9);

        // Echo colliding with a response character
        wq.delete(); dq.delete(); exp_cyc.delete();
        tick(); r = cyc;
        send_resp_val = 1'b1; send_resp_type = 2'b00;
        tick();
        send_char_val = 1'b1; send_char = 8'h41;
        repeat (8) tick();
        exp_cyc = {r + 1, r + 2, r + 3, r + 4, r + 5};
        check_seq("echo_coll", 88'("OAK\015\012"), 5, r + 6);

        // Echo in IDLE is written; echo with FIFO full is dropped
        wq.delete(); dq.delete(); exp_cyc.delete();
        tick(); r = cyc;
        send_char_val = 1'b1; send_char = 8'h7A;
        tick();
        send_char_val = 1'b1; send_char = 8'h79; char_fifo_full = 1'b1;
        tick();
        char_fifo_full = 1'b0;
        chrg_rd_valid = 1'b1; phi_rd_valid = 1'b1;
        repeat (4) tick();
        exp_cyc = {r + 1};
        check_seq("echo_idle", 88'("z"), 1, -1);

        // Timeout with an ignored non-matching strobe
        wq.delete(); dq.delete(); exp_cyc.delete();
        tick(); r = cyc;
        send_resp_val = 1'b1; send_resp_type = 2'b10;
        repeat (3) tick();
        phi_rd_valid = 1'b1;
        repeat (TO + 6) tick();
        for (int i = 1; i <= 5; i++) exp_cyc.push_back(r + TO + i);
        check_seq("timeout", 88'("ERR\015\012"), 5, r + TO + 6);

        // Reset after the second character abandons the response
        wq.delete(); dq.delete(); exp_cyc.delete();
        tick(); r = cyc;
        send_resp_val = 1'b1; send_resp_type = 2'b11;
        phi_rd_valid = 1'b1; phi_rd_data = 36'h1_23456789;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (15) tick();
        exp_cyc = {r + 1, r + 2};
        check_seq("rst_mid", 88'("12"), 2, -1);
        run_vec(vecs[0], 99);

        // Randomized traffic against the string-level model
        wq.delete(); dq.delete(); exp_resp.delete(); exp_echo.delete();
        for (int t = 0; t < 40; t++) begin
            typ = 2'($urandom_range(0, 3));
            d   = {4'($urandom), 32'($urandom)};
            if (typ == 2'b10) d[35:24] = '0;
            tmo = typ[1] && ($urandom_range(0, 19) == 0);
            vd  = $urandom_range(0, 6);
            model_push(tmo ? 2'b01 : typ, d);
            len = tmo ? 5 : (typ == 2'b00 ? 4 : typ == 2'b01 ? 5 : typ == 2'b10 ? 8 : 11);
            dbase = dq.size();
            rbase = nresp;
            sent = 1'b0;
            k = 0;
            tick();
            send_resp_val = 1'b1; send_resp_type = typ;
            while (dq.size() == dbase && k < 3000) begin
                chrg_rd_data = 24'($urandom);
                phi_rd_data  = {4'($urandom), 32'($urandom)};
                if (typ[1] && !tmo && !sent && k == vd) begin
                    sent = 1'b1;
                    if (typ == 2'b10) begin chrg_rd_valid = 1'b1; chrg_rd_data = d[23:0]; end
                    else begin phi_rd_valid = 1'b1; phi_rd_data = d; end
                end else if ($urandom_range(0, 3) == 0) begin
                    if (typ == 2'b10) phi_rd_valid = 1'b1;
                    else chrg_rd_valid = 1'b1;
                end
                char_fifo_full = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 5) == 0) begin
                    send_char_val = 1'b1;
                    send_char = 8'h61 + 8'($urandom_range(0, 25));
                    if (!char_fifo_full) exp_echo.push_back(send_char);
                end
                if (k > 0 && (nresp - rbase) < len - 1 && $urandom_range(0, 7) == 0) begin
                    send_resp_val = 1'b1; send_resp_type = 2'($urandom);
                end
                tick();
                k++;
            end
            chk($sformatf("rand%0d_done", t), dq.size(), dbase + 1);
            char_fifo_full = 1'b0;
            repeat (3) tick();
        end

        foreach (wq[i]) begin
            if (wq[i].b >= 8'h61 && wq[i].b <= 8'h7A) echo_got.push_back(wq[i].b);
            else resp_got.push_back(wq[i].b);
        end
        chk("rand_resp_len", resp_got.size(), exp_resp.size());
        for (int i = 0; i < resp_got.size() && i < exp_resp.size(); i++) begin
            checks++;
            if (resp_got[i] !== exp_resp[i]) begin
                errors++;
                $display("FAIL rand_resp_byte%0d: got %0h expected %0h", i, resp_got[i], exp_resp[i]);
                break;
            end
        end
        chk("rand_echo_len", echo_got.size(), exp_echo.size());
        for (int i = 0; i < echo_got.size() && i < exp_echo.size(); i++) begin
            checks++;
            if (echo_got[i] !== exp_echo[i]) begin
                errors++;
                $display("FAIL rand_echo_byte%0d: got %0h expected %0h", i, echo_got[i], exp_echo[i]);
                break;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ui_resp_gen.md
# ui_resp_gen

Response generator for the UART user interface, directly downstream of the command parser. On each one-cycle response request it writes an ASCII response into the transmit character FIFO, one character at a time, then returns a one-cycle done pulse to the parser. There are four response types: OK, ERR, charge-read data and potential-read data. It also forwards single echo characters from the parser into the same FIFO.

## Interface
Parameters:
- CWIDTH, 24: width of charge read data, zero-extended to 24 bits (6 hex chars); values above 24 are not supported.
- PWIDTH, 36: width of potential read data, zero-extended to 36 bits (9 hex chars); values above 36 are not supported.
- TIMEOUT, 1024: cycles to wait for read data before answering ERR.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- send_char_val  in  1  echo character strobe (1 cycle).
- send_char  in  8  echo character.
- send_resp_val  in  1  response request (1 cycle).
- send_resp_type  in  2  response type: 00 OK, 01 ERR, 10 DATA0 (charge), 11 DATA1 (potential).
- send_resp_done  out  1  response complete (1-cycle pulse).
- chrg_rd_valid  in  1  charge read data strobe.
- chrg_rd_data  in  CWIDTH  charge read data.
- phi_rd_valid  in  1  potential read data strobe.
- phi_rd_data  in  PWIDTH  potential read data.
- char_fifo_full  in  1  transmit FIFO full.
- char_fifo_wr  out  1  FIFO write strobe.
- char_fifo_din  out  8  FIFO write data.

## Operation
- States:
  - IDLE: waits for a request.
  - WAIT_DATA: waits for read data.
  - SEND: writes the response characters.
  - DONE: pulses send_resp_done and returns to IDLE.
- IDLE with send_resp_val:
  - Latch the type.
  - OK or ERR: go to SEND.
  - DATA0 or DATA1: go to WAIT_DATA and clear the timeout counter.
- Data capture:
  - A matching valid strobe (chrg for DATA0, phi for DATA1), whether in the request cycle or while in WAIT_DATA, loads a 36-bit holding register. Data is zero-extended; DATA0 uses bits [23:0].
  - Any transition to SEND follows that capture.
  - Non-matching valid strobes are ignored.
  - Valid strobes are also ignored in IDLE when no request is present and in SEND.
- Timeout: if the counter reaches TIMEOUT-1 in WAIT_DATA without matching valid, switch the latched type to ERR and go to SEND.
- Response strings (CR = 0x0D, LF = 0x0A):
  - OK: "OK" CR LF, 4 chars.
  - ERR: "ERR" CR LF, 5 chars.
  - DATA0: 6 hex digits, MSB nibble first, then CR LF; 8 chars.
  - DATA1: 9 hex digits, then CR LF; 11 chars.
- Hex encoding: nibble 0-9 maps to 0x30+n; 10-15 maps to 0x41+(n-10) (uppercase).
- Character index counter:
  - Starts at 0 on entry to SEND.
  - Advances only on a response write.
  - After writing index len-1, go to DONE.
- Write arbitration:
  - An echo (send_char_val) is written in any state in the cycle it arrives, if !char_fifo_full. It has priority.
  - The response character is written in SEND only when !char_fifo_full and !send_char_val; otherwise it stalls with the index held.
  - An echo arriving with char_fifo_full is dropped.
- A send_resp_val arriving outside IDLE is ignored; no queueing.
- Reset mid-response: the partial response is abandoned. No done pulse is issued, and all state and outputs return to reset values.

## Timing
- Reset values:
  - send_resp_done = 0.
  - char_fifo_wr = 0.
  - char_fifo_din = 0x00.
  - state = IDLE.
  - index, holding register and timeout counter = 0.
- All outputs are registered.
- FIFO write: char_fifo_wr and char_fifo_din are valid together for exactly one cycle per character.
- Request in cycle N, OK, no stalls:
  - Writes in cycles N+1 .. N+4.
  - send_resp_done in N+5.
- ERR: writes N+1 .. N+5, done N+6.
- DATA with matching valid in cycle M (M >= N): first digit written M+1, done in M+len+1.
- Timeout with request in cycle N: first 'E' written at N+TIMEOUT+1.
- Each stall cycle (full or echo) adds one cycle of latency.
- Throughput: at most one character per cycle.
- The next request is accepted in the cycle after done, when the state is IDLE.

## Test plan
- OK, FIFO never full: request type 00 in cycle N → bytes 0x4F 0x4B 0x0D 0x0A written in N+1..N+4; done pulse in N+5.
- DATA0 with charge 0x0ABCDE: chrg_rd_valid 2 cycles after the request → "0ABCDE" CR LF written (0x30 0x41 0x42 0x43 0x44 0x45 0x0D 0x0A); done one cycle after LF.
- DATA1 with phi 0xF_0000_0001: valid in the same cycle as the request → "F00000001" CR LF (9 digits); done after LF.
- FIFO full: char_fifo_full held high for 3 cycles mid-ERR response → writes pause, no character lost or duplicated; completes "ERR" CR LF with done delayed 3 cycles.
- Echo collision: send_char_val with 0x41 during SEND → 0x41 written that cycle; the response char is written the next cycle with order preserved.
- Timeout: DATA0 request and no valid for TIMEOUT cycles → "ERR" CR LF followed by done. Reset asserted after the 2nd character of another response → no further writes, no done, IDLE afterwards.
